// File: rtl/alu_op_sequencer.sv
// Issues one op at a time to the shared ALU; response LAT+1 cycles after accept (1 for illegal opcodes).
// Holds the response until rsp_ready, with no request queueing. ALU_SEQ_OPCOUNT_EN builds the op counter.
module alu_op_sequencer #(
  parameter int ALU_LAT    = 1,
  parameter int MULDIV_LAT = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_opcode,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [4:0]  alu_opcode,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [63:0] alu_z,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_lo,
  output logic [31:0] rsp_hi,
  output logic        rsp_err,
  output logic [31:0] op_count
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam int MAX_LAT = (ALU_LAT > MULDIV_LAT) ? ALU_LAT : MULDIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, capture, reject, done;

  function automatic logic is_legal(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR,
      OP_SHRA, OP_SHL, OP_MUL, OP_DIV, OP_NEG, OP_NOT: is_legal = 1'b1;
      default:                                         is_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    reject  = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (is_legal(req_opcode)) begin
            state_d = S_EXEC;
            cnt_d   = (req_opcode == OP_MUL || req_opcode == OP_DIV)
                      ? CNT_W'(MULDIV_LAT - 1) : CNT_W'(ALU_LAT - 1);
          end else begin
            state_d = S_RESP;
            reject  = 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          capture = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_lo     <= '0;
      rsp_hi     <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        alu_opcode <= req_opcode;
        alu_a      <= req_a;
        alu_b      <= req_b;
      end
      if (reject) begin
        rsp_lo  <= '0;
        rsp_hi  <= '0;
        rsp_err <= 1'b1;
      end else if (capture) begin
        // The ALU's divide-by-zero output is undefined, so it is never captured.
        if (alu_opcode == OP_DIV && alu_b == '0) begin
          rsp_lo  <= '0;
          rsp_hi  <= '0;
          rsp_err <= 1'b1;
        end else begin
          rsp_lo  <= alu_z[31:0];
          rsp_hi  <= alu_z[63:32];
          rsp_err <= 1'b0;
        end
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);

`ifdef ALU_SEQ_OPCOUNT_EN
  logic [31:0] op_count_q;
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)    op_count_q <= '0;
    else if (done) op_count_q <= op_count_q + 32'd1;
  end
  assign op_count = op_count_q;
`else
  logic unused_done;
  assign unused_done = done;
  assign op_count    = 32'd0;
`endif

endmodule
